// File: rtl/acc_sequencer_pkg.sv
// Shared widths, ALU command codes, opcodes and FSM encodings for the accumulator
// sequencer and its decoder.
package acc_sequencer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;

  localparam logic [SEL_W-1:0] ALU_THA = 3'd0;
  localparam logic [SEL_W-1:0] ALU_THB = 3'd1;
  localparam logic [SEL_W-1:0] ALU_ADD = 3'd2;
  localparam logic [SEL_W-1:0] ALU_SUB = 3'd3;
  localparam logic [SEL_W-1:0] ALU_AND = 3'd4;
  localparam logic [SEL_W-1:0] ALU_OR  = 3'd5;

  localparam int unsigned OP_NOP  = 0;
  localparam int unsigned OP_LDI  = 1;
  localparam int unsigned OP_ADDI = 2;
  localparam int unsigned OP_SUBI = 3;
  localparam int unsigned OP_ANDI = 4;
  localparam int unsigned OP_ORI  = 5;
  localparam int unsigned OP_JMP  = 6;
  localparam int unsigned OP_JZ   = 7;
  localparam int unsigned OP_HALT = 8;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StExec  = 2'd2;
  localparam logic [1:0] StHalt  = 2'd3;

  typedef struct packed {
    logic [SEL_W-1:0] com;
    logic             use_imm;
    logic             is_jmp;
    logic             is_jz;
    logic             is_halt;
    logic             is_illegal;
  } dec_t;

endpackage

// File: rtl/acc_decode.sv
// Combinational opcode decoder: maps an opcode to its ALU command and control flags.
module acc_decode
  import acc_sequencer_pkg::*;
#(
  parameter int unsigned OP_W = 4
) (
  input  logic [OP_W-1:0] opcode_i,
  output dec_t            dec_o
);

  always_comb begin
    dec_o = '{com: ALU_THA, use_imm: 1'b0, is_jmp: 1'b0, is_jz: 1'b0,
              is_halt: 1'b0, is_illegal: 1'b0};
    unique case (opcode_i)
      OP_W'(OP_NOP):  ;
      OP_W'(OP_LDI):  begin dec_o.com = ALU_THB; dec_o.use_imm = 1'b1; end
      OP_W'(OP_ADDI): begin dec_o.com = ALU_ADD; dec_o.use_imm = 1'b1; end
      OP_W'(OP_SUBI): begin dec_o.com = ALU_SUB; dec_o.use_imm = 1'b1; end
      OP_W'(OP_ANDI): begin dec_o.com = ALU_AND; dec_o.use_imm = 1'b1; end
      OP_W'(OP_ORI):  begin dec_o.com = ALU_OR;  dec_o.use_imm = 1'b1; end
      OP_W'(OP_JMP):  dec_o.is_jmp  = 1'b1;
      OP_W'(OP_JZ):   dec_o.is_jz   = 1'b1;
      OP_W'(OP_HALT): dec_o.is_halt = 1'b1;
      default:        dec_o.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/acc_sequencer.sv
// Fetch/execute sequencer feeding the accumulator datapath: two cycles per instruction,
// registered com/datain, JMP/JZ branching on accout, HALT with start/busy/done handshake.
module acc_sequencer
  import acc_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = 8,
  parameter int unsigned OP_W = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  output logic [PC_W-1:0]        imem_addr,
  input  logic [OP_W+DATA_W-1:0] imem_data,
  output logic [SEL_W-1:0]       com,
  output logic [DATA_W-1:0]      datain,
  input  logic [DATA_W-1:0]      accout,
  output logic                   busy,
  output logic                   done,
  output logic                   illegal
);

  localparam int unsigned IW = OP_W + DATA_W;

  logic [1:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic [SEL_W-1:0]  com_q, com_d;
  logic [DATA_W-1:0] datain_q, datain_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;

  logic [OP_W-1:0]   dec_op;
  dec_t              dec;
  logic [DATA_W-1:0] fetch_imm;
  logic [DATA_W-1:0] ir_imm;

  // One decoder serves both states: in FETCH it looks ahead at the incoming word so
  // com/datain are registered in time for EXEC; in EXEC it decodes the held ir.
  assign dec_op    = (state_q == StFetch) ? imem_data[IW-1 -: OP_W] : ir_q[IW-1 -: OP_W];
  assign fetch_imm = imem_data[DATA_W-1:0];
  assign ir_imm    = ir_q[DATA_W-1:0];

  acc_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .opcode_i (dec_op),
    .dec_o    (dec)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    com_d     = ALU_THA;
    datain_d  = '0;
    illegal_d = illegal_q;

    case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d   = StFetch;
          pc_d      = '0;
          illegal_d = 1'b0;
        end
      end
      StFetch: begin
        ir_d     = imem_data;
        pc_d     = pc_q + PC_W'(1);
        state_d  = StExec;
        com_d    = dec.com;
        datain_d = dec.use_imm ? fetch_imm : '0;
      end
      StExec: begin
        state_d = dec.is_halt ? StHalt : StFetch;
        // accout here already reflects the previous instruction's result.
        if (dec.is_jmp || (dec.is_jz && (accout == '0))) begin
          pc_d = PC_W'(ir_imm);
        end
        if (dec.is_illegal) begin
          illegal_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StFetch) || (state_d == StExec);
    done_d = (state_d == StHalt);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      com_q     <= ALU_THA;
      datain_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      com_q     <= com_d;
      datain_q  <= datain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_addr = pc_q;
  assign com       = com_q;
  assign datain    = datain_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench: sequencer + behavioural accumulator datapath + ROM, checked by a program-level
// interpreter through a scoreboard drained whenever done rises.
module tb_acc_sequencer;
  import acc_sequencer_pkg::*;

  localparam int PC_W = 8;
  localparam int OP_W = 4;
  localparam int IW   = OP_W + DATA_W;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [PC_W-1:0]   imem_addr;
  logic [IW-1:0]     imem_data;
  logic [SEL_W-1:0]  com;
  logic [DATA_W-1:0] datain;
  logic [DATA_W-1:0] accout;
  logic              busy, done, illegal;

  logic [IW-1:0] rom [256];
  assign imem_data = rom[imem_addr];

  always #5 clock = ~clock;

  acc_sequencer #(
    .PC_W (PC_W),
    .OP_W (OP_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .com       (com),
    .datain    (datain),
    .accout    (accout),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal)
  );

  // Accumulator datapath: latches the ALU result every clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) accout <= '0;
    else begin
      case (com)
        ALU_THA: accout <= accout;
        ALU_THB: accout <= datain;
        ALU_ADD: accout <= accout + datain;
        ALU_SUB: accout <= accout - datain;
        ALU_AND: accout <= accout & datain;
        ALU_OR:  accout <= accout | datain;
        default: accout <= accout;
      endcase
    end
  end

  typedef struct {
    logic [7:0] acc;
    logic       ill;
    int         cycles;
    int         sig;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_acc = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] ins(input int op, input int imm);
    return {op[3:0], imm[7:0]};
  endfunction

  function automatic void clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endfunction

  // Interpreter: runs the ROM program from address 0, returning the final accumulator,
  // illegal flag, busy-cycle count (2 per instruction) and sum of accout over busy cycles.
  function automatic exp_t model_run(input logic [7:0] acc_in);
    exp_t       e;
    logic [7:0] acc = acc_in;
    logic [7:0] pc = 8'h00;
    logic [7:0] imm;
    int         op;
    int         steps = 0;
    int         sig = 0;
    bit         ill = 0;
    bit         halted = 0;
    while (!halted && steps < 1000) begin
      op  = int'(rom[pc][11:8]);
      imm = rom[pc][7:0];
      sig += 2 * int'(acc);
      steps++;
      pc = pc + 8'd1;
      case (op)
        0: ;
        1: acc = imm;
        2: acc = acc + imm;
        3: acc = acc - imm;
        4: acc = acc & imm;
        5: acc = acc | imm;
        6: pc = imm;
        7: if (acc == 8'h00) pc = imm;
        8: halted = 1;
        default: ill = 1;
      endcase
    end
    e.acc = acc; e.ill = ill; e.cycles = 2 * steps; e.sig = sig;
    return e;
  endfunction

  // Issue one program; extra_at >= 0 adds a stray start pulse that many cycles in.
  task automatic run_prog(input int extra_at);
    exp_t e;
    bit   got = 0;
    e = model_run(model_acc);
    sb.push_back(e);
    model_acc = e.acc;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin got = 1; break; end
      start = (c == extra_at);
      @(negedge clock);
    end
    start = 1'b0;
    chk("done_reached", 32'(got), 32'd1);
    if (!got) sb.delete();
    @(negedge clock);
  endtask

  // Monitor: accumulates the busy-window trace and checks each completion against the queue.
  initial begin
    int   sig_sum = 0;
    int   cyc = 0;
    logic done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        sig_sum = 0; cyc = 0; done_prev = 1'b0;
      end else begin
        if (busy) begin
          sig_sum += int'(accout);
          cyc++;
        end
        if (done && !done_prev) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("final_acc", 32'(accout), 32'(e.acc));
            chk("illegal_flag", 32'(illegal), 32'(e.ill));
            chk("busy_cycles", 32'(cyc), 32'(e.cycles));
            chk("acc_trace", 32'(sig_sum), 32'(e.sig));
          end
          sig_sum = 0; cyc = 0;
        end
        done_prev = done;
      end
    end
  end

  initial begin
    int  len, op, imm;
    bit  hit;

    // Reset held, then released idle.
    clear_rom();
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_com", 32'(com), 32'(ALU_THA));
    chk("rst_datain", 32'(datain), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_acc", 32'(accout), 32'd0);

    // LDI 5; ADDI 3; SUBI 1; HALT
    clear_rom();
    rom[0] = ins(1, 5); rom[1] = ins(2, 3); rom[2] = ins(3, 1); rom[3] = ins(8, 0);
    run_prog(-1);
    chk("basic_acc", 32'(accout), 32'h07);
    chk("basic_done", 32'(done), 32'd1);

    // JZ taken over LDI 0xFF
    clear_rom();
    rom[0] = ins(1, 0); rom[1] = ins(7, 4); rom[2] = ins(1, 8'hFF); rom[3] = ins(8, 0);
    rom[4] = ins(5, 8'hA0); rom[5] = ins(8, 0);
    run_prog(-1);

    // JZ not taken, then ADDI 0xFF wraps 0x02 -> 0x01
    clear_rom();
    rom[0] = ins(1, 1); rom[1] = ins(7, 3); rom[2] = ins(2, 1); rom[3] = ins(8, 0);
    run_prog(-1);
    clear_rom();
    rom[0] = ins(2, 8'hFF); rom[1] = ins(8, 0);
    run_prog(-1);
    chk("wrap_add", 32'(accout), 32'h01);

    // PC wrap 0xFF -> 0x00
    clear_rom();
    rom[0] = ins(7, 5); rom[1] = ins(1, 0); rom[2] = ins(6, 8'hFF); rom[5] = ins(8, 0);
    run_prog(-1);

    // Illegal opcode, then cleared by the next start
    clear_rom();
    rom[0] = ins(12, 8'h33); rom[1] = ins(8, 0);
    run_prog(-1);
    chk("illegal_held", 32'(illegal), 32'd1);
    clear_rom();
    rom[0] = ins(1, 3); rom[1] = ins(8, 0);
    run_prog(-1);

    // Reset asserted during EXEC of ADDI
    clear_rom();
    rom[0] = ins(1, 5); rom[1] = ins(2, 3); rom[2] = ins(8, 0);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    hit = 0;
    for (int c = 0; c < 20; c++) begin
      if (com == ALU_ADD) begin hit = 1; break; end
      @(negedge clock);
    end
    chk("saw_addi_exec", 32'(hit), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_com", 32'(com), 32'(ALU_THA));
    chk("mid_rst_datain", 32'(datain), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    model_acc = 8'h00;
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);

    // Stray start while busy, then rerun from HALT
    clear_rom();
    rom[0] = ins(1, 1);
    for (int i = 1; i <= 8; i++) rom[i] = ins(2, 1);
    rom[9] = ins(8, 0);
    run_prog(3);
    run_prog(-1);

    // Random forward-branching programs
    for (int p = 0; p < 25; p++) begin
      clear_rom();
      len = $urandom_range(4, 16);
      for (int i = 0; i < len; i++) begin
        op  = (i == len - 1) ? 8 : $urandom_range(0, 15);
        imm = (op == 6 || op == 7) ? $urandom_range(i + 1, len - 1) : $urandom_range(0, 255);
        rom[i] = ins(op, imm);
      end
      run_prog((p % 4 == 0) ? 2 : -1);
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
